ring_decoder: RTL
=================

Name: ring_decoder

Overview:
- Receive-side companion to the team's one-hot ring counter. Samples a WIDTH-bit one-hot phase vector that rotates left each step (1000 -> 0001 -> 0010 -> 0100 -> 1000).
- Validates one-hot encoding and rotation order, acquires lock, decodes the phase to a binary index and counts sequence errors.
- Sits at the consumer end of any ring-counter-driven phase bus.

Parameters:
- WIDTH, 4, ring width; legal range WIDTH >= 2.
- LOCK_COUNT, 3, consecutive correct rotations required to declare lock; legal range >= 1.
- ERR_CNT_W, 8, error counter width.
- Derived: IDX_W = $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- en  input  1  sample enable; ring_in is evaluated only on edges with en=1
- ring_in  input  WIDTH  phase vector from the ring counter
- clr_err  input  1  synchronous clear of err_count
- idx  output  IDX_W  bit position of the last valid one-hot sample
- idx_valid  output  1  idx is a locked, in-sequence decode
- locked  output  1  decoder is in LOCK
- err_pulse  output  1  one-cycle pulse per sequence error while locked
- err_count  output  ERR_CNT_W  saturating error count

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. rst_n low at a rising edge overrides everything, including mid-lock.
- Reset values: state=HUNT, prev=0, match_cnt=0, idx=0, idx_valid=0, locked=0, err_pulse=0, err_count=0.
- Latency: all outputs are registered and reflect the sample taken at the same edge, one cycle after ring_in is presented.
- Definitions:
  - onehot = exactly one bit of ring_in is set.
  - expected = {prev[WIDTH-2:0], prev[WIDTH-1]}.
  - match = onehot && ring_in == expected.
- en=0 edge:
  - state, prev, match_cnt, idx and locked hold.
  - idx_valid=0 and err_pulse=0.
  - clr_err is still honoured.
- HUNT:
  - If onehot: prev<=ring_in, idx<=position, match_cnt<=0, go to ACQ.
  - Otherwise stay in HUNT.
- ACQ:
  - On match: prev<=ring_in, idx updates, match_cnt++. If match_cnt reaches LOCK_COUNT, go to LOCK, with locked=1 and idx_valid=1 at that same edge.
  - On onehot mismatch: restart ACQ with prev<=ring_in and match_cnt<=0.
  - On a non-one-hot sample: go to HUNT, prev<=0.
  - No errors are counted in HUNT or ACQ.
- LOCK:
  - On match: prev<=ring_in, idx updates, idx_valid=1.
  - On mismatch: err_pulse=1, err_count increments, locked=0, idx_valid=0.
    - If the failing sample is onehot: go to ACQ with prev<=ring_in and match_cnt<=0.
    - Otherwise: go to HUNT.
- Ring wrap: the index sequence for the WIDTH=4 example is 3,0,1,2,3. The MSB-to-LSB rotation is a normal match.
- err_count:
  - Saturates at all ones; does not wrap.
  - If clr_err and an error occur on the same edge, err_count=1.
  - If clr_err occurs alone, err_count=0.
- The all-zero vector and any multi-hot vector are never onehot.

Optional Feature:
- Macro: RING_DECODE_FLYWHEEL_EN.
- Without it: any mismatch in LOCK drops lock as described above.
- With it, LOCK tolerates one isolated error:
  - First mismatch: err_pulse=1, err_count++, idx_valid=0, locked stays 1. prev<=expected and idx<=expected position, so the decoder free-wheels.
  - Next enabled sample:
    - If it matches the rotation of the flywheeled prev, normal LOCK resumes.
    - A second consecutive mismatch gives a second err_pulse and count, then exits LOCK per the normal rules.
- Ports are identical in both builds.

Test Plan:
- Reset, en=1, feed 1000,0001,0010,0100,1000 -> locked=0 for samples 1-3; after sample 4 locked=1, idx=2, idx_valid=1; after sample 5 idx=3.
- While locked, feed 0011 -> err_pulse for exactly one cycle, err_count=1, locked=0, state HUNT. Then feed 0001,0010,0100,1000 -> relock after the 4th sample.
- Locked on 1000, feed out-of-order 0100 -> err_count increments, state ACQ with prev=0100. Then feed 1000,0001,0010 -> locked=1 after 0010.
- Locked, with en toggling 1,0,0,1 and a correct next phase -> idx_valid=0 on the en=0 cycles, locked stays 1, no err_pulse.
- Build with ERR_CNT_W=2 and force 5 errors -> err_count saturates at 3. Then assert clr_err together with an error -> err_count=1. Assert rst_n=0 while locked -> all outputs at reset values after one edge.
- Build with RING_DECODE_FLYWHEEL_EN: locked on 0001, feed 1111 then 0100 -> locked stays 1, err_count=1, idx=2, idx_valid=1. Then feed 0000, 0000 -> two err_pulses and locked=0.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder: checks a rotating one-hot phase vector, acquires lock, decodes the phase index and counts sequence errors.
// Build option RING_DECODE_FLYWHEEL_EN lets LOCK ride through one isolated error.
module ring_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, ACQ = 2'd1, LOCK = 2'd2} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] match_cnt;
    logic [WIDTH-1:0] expected;
    logic             onehot;
    logic             match;
    logic             err_evt;
`ifdef RING_DECODE_FLYWHEEL_EN
    logic             fly;
`endif

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) ones += int'(v[i]);
        return ones == 1;
    endfunction

    function automatic logic [IDX_W-1:0] pos_of(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) p = IDX_W'(i);
        return p;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign onehot   = is_onehot(ring_in);
    assign match    = onehot && (ring_in == expected);
    assign err_evt  = en && (state == LOCK) && !match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            prev      <= '0;
            match_cnt <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
`ifdef RING_DECODE_FLYWHEEL_EN
            fly       <= 1'b0;
`endif
        end else begin
            idx_valid <= 1'b0;
            err_pulse <= err_evt;
            if (clr_err)      err_count <= err_evt ? ERR_CNT_W'(1) : '0;
            else if (err_evt) err_count <= sat_inc(err_count);

            if (en) begin
                case (state)
                    HUNT: begin
                        if (onehot) begin
                            prev      <= ring_in;
                            idx       <= pos_of(ring_in);
                            match_cnt <= '0;
                            state     <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (match) begin
                            prev      <= ring_in;
                            idx       <= pos_of(ring_in);
                            match_cnt <= match_cnt + CNT_W'(1);
                            if (match_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                                state     <= LOCK;
                                locked    <= 1'b1;
                                idx_valid <= 1'b1;
                            end
                        end else if (onehot) begin
                            prev      <= ring_in;
                            match_cnt <= '0;
                        end else begin
                            prev  <= '0;
                            state <= HUNT;
                        end
                    end
                    LOCK: begin
                        if (match) begin
                            prev      <= ring_in;
                            idx       <= pos_of(ring_in);
                            idx_valid <= 1'b1;
`ifdef RING_DECODE_FLYWHEEL_EN
                            fly       <= 1'b0;
                        end else if (!fly) begin
                            // Free-wheel: pretend the expected phase arrived.
                            fly  <= 1'b1;
                            prev <= expected;
                            idx  <= pos_of(expected);
                        end else begin
                            fly    <= 1'b0;
`else
                        end else begin
`endif
                            locked <= 1'b0;
                            if (onehot) begin
                                prev      <= ring_in;
                                match_cnt <= '0;
                                state     <= ACQ;
                            end else begin
                                prev  <= '0;
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule
